// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU: grant, register operands, capture result, respond.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (requester 0).
module alu_arbiter #(
  parameter int N_BITS_DATA  = 8,
  parameter int N_BITS_OP    = 6,
  parameter int N_BITS_STATE = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [2*N_BITS_DATA-1:0] req_a_i,
  input  logic [2*N_BITS_DATA-1:0] req_b_i,
  input  logic [2*N_BITS_OP-1:0]   req_op_i,
  output logic [1:0]               resp_valid_o,
  input  logic [1:0]               resp_ready_i,
  output logic [N_BITS_DATA-1:0]   resp_data_o,
  output logic [1:0]               grant_o,
  output logic                     busy_o,
  output logic [N_BITS_DATA-1:0]   dataA_o,
  output logic [N_BITS_DATA-1:0]   dataB_o,
  output logic [N_BITS_OP-1:0]     dataOp_o,
  input  logic [N_BITS_DATA-1:0]   result_alu_i
);

  typedef enum logic [N_BITS_STATE-1:0] {
    IDLE = 3'b001,
    EXEC = 3'b010,
    RESP = 3'b100
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [N_BITS_DATA-1:0] data_a_q, data_a_d;
  logic [N_BITS_DATA-1:0] data_b_q, data_b_d;
  logic [N_BITS_OP-1:0]   data_op_q, data_op_d;
  logic [N_BITS_DATA-1:0] resp_data_q, resp_data_d;
  logic [1:0]             req_ready;
  logic [1:0]             resp_valid;
  logic                   win;

  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    win = (&req_valid_i) ? ~last_grant_q : ~req_valid_i[0];
`else
    win = ~req_valid_i[0];
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    data_op_d    = data_op_q;
    resp_data_d  = resp_data_q;
    req_ready    = '0;
    resp_valid   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready    = win ? 2'b10 : 2'b01;
          grant_d      = win ? 2'b10 : 2'b01;
          last_grant_d = win;
          data_a_d     = win ? req_a_i[2*N_BITS_DATA-1:N_BITS_DATA] : req_a_i[N_BITS_DATA-1:0];
          data_b_d     = win ? req_b_i[2*N_BITS_DATA-1:N_BITS_DATA] : req_b_i[N_BITS_DATA-1:0];
          data_op_d    = win ? req_op_i[2*N_BITS_OP-1:N_BITS_OP] : req_op_i[N_BITS_OP-1:0];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = result_alu_i;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid = grant_q;
        // Only the owner's ready bit can complete the handshake.
        if (|(resp_ready_i & grant_q)) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      data_a_q     <= '0;
      data_b_q     <= '0;
      data_op_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      data_op_q    <= data_op_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign req_ready_o  = req_ready & {2{reset}};
  assign resp_valid_o = resp_valid;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != IDLE);
  assign dataA_o      = data_a_q;
  assign dataB_o      = data_b_q;
  assign dataOp_o     = data_op_q;
  assign resp_data_o  = resp_data_q;

endmodule
